// File: rtl/pulse_cmd_uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// pulse_cmd_uart_rx_pkg
//   Shared definitions for the pulse_gen command receiver:
//   - the CONT_* command IDs understood by the pulse_gen control registers
//   - the number of valid command IDs
//   - the bit-period derivation from clock frequency and baud rate
//   - the state encoding of the serial bit FSM
// ---------------------------------------------------------------------------
package pulse_cmd_uart_rx_pkg;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;

    // Rounded to the nearest whole clock so the sampling centre drifts as
    // little as possible over a 10-bit character.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int DEFAULT_CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);

    typedef enum logic [7:0] {
        CONT_SET_DELAY    = 8'd0,
        CONT_SET_WIDTH    = 8'd1,
        CONT_SET_PERIOD   = 8'd2,
        CONT_SET_COUNT    = 8'd3,
        CONT_SET_POLARITY = 8'd4,
        CONT_SET_ENABLE   = 8'd5,
        CONT_SET_TRIGGER  = 8'd6,
        CONT_SET_MODE     = 8'd7,
        CONT_SET_NUTD     = 8'd8
    } cont_cmd_t;

    localparam int CONT_NUM_CMDS = 9;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/pulse_cmd_uart_rx_if.sv
// ---------------------------------------------------------------------------
// pulse_cmd_uart_rx_if
//   Command/status bundle produced by the UART command receiver.
//   master : the receiver (drives everything)
//   slave  : the consumer (pulse_gen control registers)
//   cmd_valid   1-cycle strobe, cmd_id/cmd_data valid this cycle
//   cmd_id      command ID, held until the next cmd_valid
//   cmd_data    payload, byte 0 in bits [7:0]
//   err_frame   stop bit sampled low
//   err_timeout partial frame abandoned
//   err_cmd     complete frame with an unknown ID
//   busy        frame reception in progress
// ---------------------------------------------------------------------------
interface pulse_cmd_uart_rx_if #(
    parameter int PAYLOAD_BYTES = 4
);
    logic                         cmd_valid;
    logic [7:0]                   cmd_id;
    logic [8*PAYLOAD_BYTES-1:0]   cmd_data;
    logic                         err_frame;
    logic                         err_timeout;
    logic                         err_cmd;
    logic                         busy;

    modport master (
        output cmd_valid, cmd_id, cmd_data, err_frame, err_timeout, err_cmd, busy
    );

    modport slave (
        input cmd_valid, cmd_id, cmd_data, err_frame, err_timeout, err_cmd, busy
    );
endinterface

// File: rtl/pulse_cmd_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 byte receiver: 2-flop synchroniser, bit FSM and 3-sample majority
//   vote around each bit centre.
//   clk, resetn  system clock, synchronous active-low reset
//   rx           asynchronous serial input, idle high
//   byte_valid   1-cycle strobe, rx_byte holds the received byte
//   rx_byte      last received byte
//   frame_err    1-cycle strobe, stop bit voted low
//   start_det    falling edge seen while idle (candidate start bit)
//   active       start bit confirmed, data/stop bits being received
//   idle         bit FSM is waiting for a start bit
// ---------------------------------------------------------------------------
module uart_rx_byte
    import pulse_cmd_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       start_det,
    output logic       active,
    output logic       idle
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] VOTE_A = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] VOTE_B = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] VOTE_C = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);

    rx_state_t   state, state_next;
    logic [1:0]  sync;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  votes;
    logic [7:0]  shift;
    logic        rx_s;
    logic        at_vote;
    logic        at_end;
    logic        maj;
    logic        done_now;
    logic        err_now;

    assign rx_s    = sync[1];
    assign at_vote = (cnt == VOTE_C);
    assign at_end  = (cnt == LAST);
    // The third sample is the live synchronised value at VOTE_C.
    assign maj     = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:      if (!rx_s) state_next = RX_START;
            RX_START: begin
                if (at_vote && maj)  state_next = RX_IDLE;
                else if (at_end)     state_next = RX_DATA;
            end
            RX_DATA:      if (at_end && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP: begin
                if (at_vote && !maj) state_next = RX_WAIT_HIGH;
                else if (at_end)     state_next = RX_IDLE;
            end
            RX_WAIT_HIGH: if (rx_s) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        start_det = (state == RX_IDLE) && !rx_s;
        done_now  = (state == RX_STOP) && at_end;
        err_now   = (state == RX_STOP) && at_vote && !maj;
        active    = (state == RX_DATA) || (state == RX_STOP);
        idle      = (state == RX_IDLE);
    end

    // The cycle that detects the start edge counts as position 0 of the bit,
    // so START is entered with cnt = 1. The stop bit is timed to its end so
    // the next start edge lands on the first IDLE cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync       <= 2'b11;
            cnt        <= '0;
            bit_idx    <= '0;
            votes      <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            byte_valid <= done_now;
            frame_err  <= err_now;

            case (state)
                RX_START, RX_DATA, RX_STOP: cnt <= at_end ? '0 : cnt + CW'(1);
                RX_IDLE:                    cnt <= CW'(1);
                default:                    cnt <= '0;
            endcase

            if (cnt == VOTE_A) votes[0] <= rx_s;
            if (cnt == VOTE_B) votes[1] <= rx_s;

            if (state == RX_IDLE) begin
                bit_idx <= '0;
            end else if (state == RX_DATA) begin
                if (at_vote) shift <= {maj, shift[7:1]};
                if (at_end)  bit_idx <= (bit_idx == 3'd7) ? 3'd0 : bit_idx + 3'd1;
            end

            if (done_now) rx_byte <= shift;
        end
    end

endmodule

// File: rtl/pulse_cmd_uart_rx.sv
// ---------------------------------------------------------------------------
// pulse_cmd_uart_rx
//   UART command deframer for the pulse_gen control registers. One command
//   frame is an ID byte followed by PAYLOAD_BYTES little-endian payload bytes.
//   clk       system clock
//   resetn    synchronous active-low reset
//   RS232_Rx  asynchronous serial input, idle high
//   cmd       pulse_cmd_uart_rx_if.master: cmd_valid/cmd_id/cmd_data,
//             err_frame/err_timeout/err_cmd strobes, busy
// ---------------------------------------------------------------------------
module pulse_cmd_uart_rx
    import pulse_cmd_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int PAYLOAD_BYTES = 4,
    parameter int TIMEOUT_BITS  = 20,
    parameter int NUM_CMDS      = CONT_NUM_CMDS
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               RS232_Rx,
    pulse_cmd_uart_rx_if.master cmd
);

    localparam int IW        = $clog2(PAYLOAD_BYTES + 1);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW        = $clog2(TMO_LIMIT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TMO_LIMIT);
    localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_BYTES);
    localparam logic [7:0]    ID_LIMIT = 8'(NUM_CMDS);

    logic                          byte_valid;
    logic [7:0]                    rx_byte;
    logic                          frame_err;
    logic                          start_det;
    logic                          rx_active;
    logic                          rx_idle;

    logic [IW-1:0]                 idx;
    logic [7:0]                    id_q;
    logic [PAYLOAD_BYTES-1:0][7:0] payload_q;
    logic [PAYLOAD_BYTES-1:0][7:0] payload_next;
    logic [TW-1:0]                 tmo;
    logic                          tmo_fire;
    logic                          last_byte;

    logic                          cmd_valid_q;
    logic [7:0]                    cmd_id_q;
    logic [8*PAYLOAD_BYTES-1:0]    cmd_data_q;
    logic                          err_frame_q;
    logic                          err_timeout_q;
    logic                          err_cmd_q;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (RS232_Rx),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err),
        .start_det  (start_det),
        .active     (rx_active),
        .idle       (rx_idle)
    );

    // Merging the incoming byte combinationally lets the final payload byte
    // reach cmd_data in the same cycle cmd_valid is raised.
    always_comb begin
        payload_next = payload_q;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (byte_valid && idx == IW'(i + 1)) payload_next[i] = rx_byte;
        end
        last_byte = byte_valid && (idx == IDX_LAST);
        tmo_fire  = (idx != '0) && rx_idle && !start_det && (tmo == TMO_MAX);
    end

    // Inter-byte idle counter; any start edge or an empty frame clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tmo <= '0;
        end else if (start_det || idx == '0) begin
            tmo <= '0;
        end else if (rx_idle) begin
            tmo <= (tmo == TMO_MAX) ? '0 : tmo + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx           <= '0;
            id_q          <= '0;
            payload_q     <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_id_q      <= '0;
            cmd_data_q    <= '0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cmd_q     <= 1'b0;
        end else begin
            cmd_valid_q   <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_cmd_q     <= 1'b0;

            if (frame_err) begin
                err_frame_q <= 1'b1;
                idx         <= '0;
            end else if (tmo_fire) begin
                err_timeout_q <= 1'b1;
                idx           <= '0;
            end else if (byte_valid) begin
                if (idx == '0) begin
                    id_q <= rx_byte;
                    idx  <= IW'(1);
                end else begin
                    payload_q <= payload_next;
                    if (last_byte) begin
                        idx <= '0;
                        if (id_q < ID_LIMIT) begin
                            cmd_valid_q <= 1'b1;
                            cmd_id_q    <= id_q;
                            cmd_data_q  <= payload_next;
                        end else begin
                            err_cmd_q <= 1'b1;
                        end
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
            end
        end
    end

    assign cmd.cmd_valid   = cmd_valid_q;
    assign cmd.cmd_id      = cmd_id_q;
    assign cmd.cmd_data    = cmd_data_q;
    assign cmd.err_frame   = err_frame_q;
    assign cmd.err_timeout = err_timeout_q;
    assign cmd.err_cmd     = err_cmd_q;
    assign cmd.busy        = (idx != '0) || rx_active;

endmodule

// File: tb/tb_pulse_cmd_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_pulse_cmd_uart_rx
//   Directed bench for pulse_cmd_uart_rx. Instance A uses 4 payload bytes
//   with a shortened bit period to keep the run short; instance B uses
//   2 payload bytes and CLKS_PER_BIT = 16.
// ---------------------------------------------------------------------------
module tb_pulse_cmd_uart_rx;

    localparam int A_CPB = 32;
    localparam int B_CPB = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    bit   sel_b = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    int n_valid_a = 0, n_frame_a = 0, n_tmo_a = 0, n_cmd_a = 0, n_busy_a = 0;
    int n_valid_b = 0, n_err_b = 0;

    pulse_cmd_uart_rx_if #(.PAYLOAD_BYTES(4)) cmd_a ();
    pulse_cmd_uart_rx_if #(.PAYLOAD_BYTES(2)) cmd_b ();

    pulse_cmd_uart_rx #(
        .CLKS_PER_BIT (A_CPB),
        .PAYLOAD_BYTES(4),
        .TIMEOUT_BITS (20),
        .NUM_CMDS     (9)
    ) dut_a (
        .clk      (clk),
        .resetn   (resetn),
        .RS232_Rx (rx_a),
        .cmd      (cmd_a)
    );

    pulse_cmd_uart_rx #(
        .CLKS_PER_BIT (B_CPB),
        .PAYLOAD_BYTES(2),
        .TIMEOUT_BITS (20),
        .NUM_CMDS     (9)
    ) dut_b (
        .clk      (clk),
        .resetn   (resetn),
        .RS232_Rx (rx_b),
        .cmd      (cmd_b)
    );

    always #10 clk = ~clk;

    // Strobe and busy-cycle counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (cmd_a.cmd_valid)   n_valid_a++;
        if (cmd_a.err_frame)   n_frame_a++;
        if (cmd_a.err_timeout) n_tmo_a++;
        if (cmd_a.err_cmd)     n_cmd_a++;
        if (cmd_a.busy)        n_busy_a++;
        if (cmd_b.cmd_valid)   n_valid_b++;
        if (cmd_b.err_frame || cmd_b.err_timeout || cmd_b.err_cmd) n_err_b++;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v);
        if (sel_b) rx_b = v;
        else       rx_a = v;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 character; glitch_bit selects a data bit that gets a 1-clk low
    // pulse exactly on its centre sample (-1 for none).
    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit,
                                  input int glitch_bit, input int cpb);
        drive(1'b0);
        idle_cycles(cpb);
        for (int i = 0; i < 8; i++) begin
            drive(b[i]);
            if (i == glitch_bit) begin
                idle_cycles(cpb / 2);
                drive(1'b0);
                idle_cycles(1);
                drive(b[i]);
                idle_cycles(cpb - cpb / 2 - 1);
            end else begin
                idle_cycles(cpb);
            end
        end
        drive(stop_bit);
        idle_cycles(cpb);
        if (!stop_bit) begin
            drive(1'b1);
            idle_cycles(cpb);
        end
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [63:0] data,
                              input int nbytes, input int id_glitch, input int cpb);
        apply_stimulus(id, 1'b1, id_glitch, cpb);
        for (int k = 0; k < nbytes; k++) begin
            apply_stimulus(data[8*k +: 8], 1'b1, -1, cpb);
        end
    endtask

    initial begin
        int v0, e0, b0;

        idle_cycles(4);
        check_output("reset_cmd_id_a",   64'(cmd_a.cmd_id),   64'h0);
        check_output("reset_cmd_data_a", 64'(cmd_a.cmd_data), 64'h0);
        check_output("reset_busy_a",     64'(cmd_a.busy),     64'h0);
        check_output("reset_cmd_id_b",   64'(cmd_b.cmd_id),   64'h0);
        resetn = 1'b1;
        idle_cycles(4);

        // 1: basic command
        sel_b = 1'b0;
        send_frame(8'h00, 64'h64, 4, -1, A_CPB);
        idle_cycles(A_CPB);
        check_output("t1_valid_count", 64'(n_valid_a), 64'd1);
        check_output("t1_cmd_id",      64'(cmd_a.cmd_id),   64'h0);
        check_output("t1_cmd_data",    64'(cmd_a.cmd_data), 64'h64);
        check_output("t1_no_errors",   64'(n_frame_a + n_tmo_a + n_cmd_a), 64'd0);

        // 2: centre-sample glitch on ID bit 2, then a 100 ns idle pulse
        send_frame(8'h07, 64'hA5A5_A5A5, 4, 2, A_CPB);
        idle_cycles(A_CPB);
        check_output("t2_valid_count", 64'(n_valid_a), 64'd2);
        check_output("t2_cmd_id",      64'(cmd_a.cmd_id),   64'h7);
        check_output("t2_cmd_data",    64'(cmd_a.cmd_data), 64'hA5A5_A5A5);
        b0 = n_busy_a;
        e0 = n_frame_a + n_tmo_a + n_cmd_a;
        drive(1'b0);
        idle_cycles(5);
        drive(1'b1);
        idle_cycles(3 * A_CPB);
        check_output("t2_idle_pulse_busy", 64'(n_busy_a - b0), 64'd0);
        check_output("t2_idle_pulse_err",  64'(n_frame_a + n_tmo_a + n_cmd_a - e0), 64'd0);

        // 3: stop bit of payload byte 2 low, then a clean frame
        apply_stimulus(8'h02, 1'b1, -1, A_CPB);
        apply_stimulus(8'h11, 1'b1, -1, A_CPB);
        apply_stimulus(8'h22, 1'b1, -1, A_CPB);
        apply_stimulus(8'h33, 1'b0, -1, A_CPB);
        idle_cycles(A_CPB);
        check_output("t3_err_frame", 64'(n_frame_a), 64'd1);
        check_output("t3_no_valid",  64'(n_valid_a), 64'd2);
        check_output("t3_busy_low",  64'(cmd_a.busy), 64'h0);
        send_frame(8'h05, 64'hDEAD_BEEF, 4, -1, A_CPB);
        idle_cycles(A_CPB);
        check_output("t3_valid_count", 64'(n_valid_a), 64'd3);
        check_output("t3_cmd_id",      64'(cmd_a.cmd_id),   64'h5);
        check_output("t3_cmd_data",    64'(cmd_a.cmd_data), 64'hDEAD_BEEF);

        // 4: partial frame abandoned by the idle timeout
        send_frame(8'h03, 64'h5566, 2, -1, A_CPB);
        idle_cycles(2);
        check_output("t4_busy_partial", 64'(cmd_a.busy), 64'h1);
        idle_cycles(21 * A_CPB);
        check_output("t4_err_timeout", 64'(n_tmo_a), 64'd1);
        check_output("t4_busy_fell",   64'(cmd_a.busy), 64'h0);
        check_output("t4_no_valid",    64'(n_valid_a), 64'd3);
        send_frame(8'h03, 64'h00C0_FFEE, 4, -1, A_CPB);
        idle_cycles(A_CPB);
        check_output("t4_valid_count", 64'(n_valid_a), 64'd4);
        check_output("t4_cmd_id",      64'(cmd_a.cmd_id),   64'h3);
        check_output("t4_cmd_data",    64'(cmd_a.cmd_data), 64'h00C0_FFEE);

        // 5: unknown ID keeps the previous command
        send_frame(8'h0C, 64'h1122_3344, 4, -1, A_CPB);
        idle_cycles(A_CPB);
        check_output("t5_err_cmd",     64'(n_cmd_a), 64'd1);
        check_output("t5_no_valid",    64'(n_valid_a), 64'd4);
        check_output("t5_cmd_id_held", 64'(cmd_a.cmd_id),   64'h3);
        check_output("t5_cmd_data_held", 64'(cmd_a.cmd_data), 64'h00C0_FFEE);

        // 6: reset mid-payload on A
        e0 = n_frame_a + n_tmo_a + n_cmd_a;
        apply_stimulus(8'h08, 1'b1, -1, A_CPB);
        apply_stimulus(8'hAA, 1'b1, -1, A_CPB);
        drive(1'b0);
        idle_cycles(3 * A_CPB);
        resetn = 1'b0;
        idle_cycles(3);
        drive(1'b1);
        idle_cycles(3);
        check_output("t6_reset_cmd_id",   64'(cmd_a.cmd_id),   64'h0);
        check_output("t6_reset_cmd_data", 64'(cmd_a.cmd_data), 64'h0);
        check_output("t6_reset_busy",     64'(cmd_a.busy),     64'h0);
        resetn = 1'b1;
        idle_cycles(2 * A_CPB);
        send_frame(8'h01, 64'h0000_03E8, 4, -1, A_CPB);
        idle_cycles(A_CPB);
        check_output("t6_valid_count", 64'(n_valid_a), 64'd5);
        check_output("t6_cmd_id",      64'(cmd_a.cmd_id),   64'h1);
        check_output("t6_cmd_data",    64'(cmd_a.cmd_data), 64'h3E8);
        check_output("t6_no_errors",   64'(n_frame_a + n_tmo_a + n_cmd_a - e0), 64'd0);

        // B: 2-byte payload, 16 clocks per bit, back-to-back frames
        sel_b = 1'b1;
        v0 = n_valid_b;
        send_frame(8'h02, 64'h1234, 2, -1, B_CPB);
        send_frame(8'h04, 64'hBEEF, 2, -1, B_CPB);
        idle_cycles(B_CPB);
        check_output("b_b2b_valid_count", 64'(n_valid_b - v0), 64'd2);
        check_output("b_b2b_cmd_id",      64'(cmd_b.cmd_id),   64'h4);
        check_output("b_b2b_cmd_data",    64'(cmd_b.cmd_data), 64'hBEEF);

        apply_stimulus(8'h06, 1'b1, -1, B_CPB);
        drive(1'b0);
        idle_cycles(4 * B_CPB);
        resetn = 1'b0;
        idle_cycles(3);
        drive(1'b1);
        idle_cycles(3);
        check_output("b_reset_cmd_data", 64'(cmd_b.cmd_data), 64'h0);
        resetn = 1'b1;
        idle_cycles(2 * B_CPB);
        v0 = n_valid_b;
        send_frame(8'h01, 64'h03E8, 2, -1, B_CPB);
        idle_cycles(B_CPB);
        check_output("b_valid_count", 64'(n_valid_b - v0), 64'd1);
        check_output("b_cmd_id",      64'(cmd_b.cmd_id),   64'h1);
        check_output("b_cmd_data",    64'(cmd_b.cmd_data), 64'h03E8);
        check_output("b_no_errors",   64'(n_err_b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
